qnigma_mdio_master: RTL and testbench

- Parametrised MDIO management master; successor to the fixed Clause-22 serialiser.
- Supports Clause 22 and Clause 45 frames, configurable preamble length (including full suppression) and MDC divider.
- Adds turnaround-acknowledge checking and a valid/ready request plus pulsed response interface.
- Sits between the PHY/MAC management controller and the MDC/MDIO pads; the pad tri-state is external.

---
 rtl/qnigma_mdio_master.sv | 233 +++++++++++++++++++++++
 tb/tb_qnigma_mdio_master.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/qnigma_mdio_master.sv
// qnigma_mdio_master: MDIO management master for Clause 22 and Clause 45 frames.
// Serialises one request at a time onto MDC/MDO/MDT and returns read data or
// an error through a one-cycle response pulse. Pad tri-state lives outside.
module qnigma_mdio_master #(
  parameter int MDC_DIV       = 20,
  parameter int PREAMBLE_BITS = 32,
  parameter bit CLAUSE45_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_c45,
  input  logic [1:0]  req_op,
  input  logic [4:0]  req_phyad,
  input  logic [4:0]  req_regad,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdo,
  output logic        mdt,
  input  logic        mdi
);

  localparam int CW = $clog2(MDC_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(MDC_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(MDC_DIV / 2);
  localparam logic [5:0] PRE_LAST = (PREAMBLE_BITS > 0) ? 6'(PREAMBLE_BITS - 1) : 6'd0;

  // S_ERR is the single cycle that holds req_ready low after an illegal request
  typedef enum logic [3:0] {
    S_IDLE, S_ERR, S_PRE, S_ST, S_OP, S_PHY, S_REG, S_TA, S_DATA, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    bitCnt_q, bitCnt_d;
  logic [31:0]   tx_q, tx_d;
  logic [15:0]   rx_q, rx_d;
  logic          isRead_q, isRead_d;
  logic          taErr_q, taErr_d;
  logic          mdc_q, mdc_d;
  logic          mdo_q, mdo_d;
  logic          mdt_q, mdt_d;
  logic          ready_q, ready_d;
  logic          rspValid_q, rspValid_d;
  logic          rspErr_q, rspErr_d;
  logic [15:0]   rspData_q, rspData_d;

  logic        reqC45;
  logic        reqRead;
  logic        reqIllegal;
  logic [31:0] frameWord;
  state_t      nextPhase;

  // Last bit index of each serial phase
  function automatic logic [5:0] phaseLast(input state_t s);
    case (s)
      S_PRE:               phaseLast = PRE_LAST;
      S_ST, S_OP, S_TA:    phaseLast = 6'd1;
      S_PHY, S_REG:        phaseLast = 6'd4;
      S_DATA:              phaseLast = 6'd15;
      default:             phaseLast = 6'd0;
    endcase
  endfunction

  // Phase order of a frame
  function automatic state_t phaseSucc(input state_t s);
    case (s)
      S_PRE:   phaseSucc = S_ST;
      S_ST:    phaseSucc = S_OP;
      S_OP:    phaseSucc = S_PHY;
      S_PHY:   phaseSucc = S_REG;
      S_REG:   phaseSucc = S_TA;
      S_TA:    phaseSucc = S_DATA;
      S_DATA:  phaseSucc = S_GAP;
      default: phaseSucc = S_IDLE;
    endcase
  endfunction

  // Decode the incoming request into the 32 bits that follow the preamble
  always_comb begin
    reqC45     = CLAUSE45_EN && req_c45;
    reqRead    = req_op[1];
    reqIllegal = !reqC45 && ((req_op == 2'b00) || (req_op == 2'b11));
    frameWord  = {reqC45 ? 2'b00 : 2'b01, req_op, req_phyad, req_regad,
                  reqRead ? 2'b00 : 2'b10, reqRead ? 16'h0000 : req_data};
  end

  // Next-state logic: divider, phase sequencing, bit shifting and responses
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitCnt_d   = bitCnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    isRead_d   = isRead_q;
    taErr_d    = taErr_q;
    mdc_d      = mdc_q;
    mdo_d      = mdo_q;
    mdt_d      = mdt_q;
    ready_d    = ready_q;
    rspValid_d = 1'b0;
    rspErr_d   = rspErr_q;
    rspData_d  = rspData_q;
    nextPhase  = state_q;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        mdc_d = 1'b0;
        if (req_valid && ready_q) begin
          ready_d = 1'b0;
          if (reqIllegal) begin
            rspValid_d = 1'b1;
            rspErr_d   = 1'b1;
            rspData_d  = 16'h0000;
            state_d    = S_ERR;
          end else begin
            isRead_d = reqRead;
            taErr_d  = 1'b0;
            rx_d     = 16'h0000;
            bitCnt_d = 6'd0;
            mdt_d    = 1'b1;
            if (PREAMBLE_BITS > 0) begin
              state_d = S_PRE;
              mdo_d   = 1'b1;
              tx_d    = frameWord;
            end else begin
              state_d = S_ST;
              mdo_d   = frameWord[31];
              tx_d    = {frameWord[30:0], 1'b0};
            end
          end
        end
      end

      S_ERR: begin
        ready_d = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        mdc_d = (cnt_d >= CNT_HALF);

        if (cnt_q == CNT_HALF && isRead_q) begin
          if (state_q == S_TA && bitCnt_q == 6'd1) begin
            taErr_d = mdi;
          end
          if (state_q == S_DATA) begin
            rx_d = {rx_q[14:0], mdi};
          end
        end

        if (cnt_q == CNT_LAST) begin
          if (state_q == S_GAP) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            if (bitCnt_q == phaseLast(state_q)) begin
              nextPhase = phaseSucc(state_q);
              bitCnt_d  = 6'd0;
            end else begin
              bitCnt_d  = bitCnt_q + 6'd1;
            end
            state_d = nextPhase;
            if (nextPhase == S_GAP) begin
              mdo_d      = 1'b0;
              mdt_d      = 1'b0;
              rspValid_d = 1'b1;
              rspErr_d   = isRead_q && taErr_q;
              rspData_d  = isRead_q ? rx_q : 16'h0000;
            end else if (nextPhase == S_PRE) begin
              mdo_d = 1'b1;
              mdt_d = 1'b1;
            end else begin
              mdo_d = tx_q[31];
              tx_d  = {tx_q[30:0], 1'b0};
              mdt_d = !(isRead_q && (nextPhase == S_TA || nextPhase == S_DATA));
            end
          end
        end
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame without a response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitCnt_q   <= 6'd0;
      tx_q       <= 32'h0;
      rx_q       <= 16'h0;
      isRead_q   <= 1'b0;
      taErr_q    <= 1'b0;
      mdc_q      <= 1'b0;
      mdo_q      <= 1'b0;
      mdt_q      <= 1'b0;
      ready_q    <= 1'b1;
      rspValid_q <= 1'b0;
      rspErr_q   <= 1'b0;
      rspData_q  <= 16'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitCnt_q   <= bitCnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      isRead_q   <= isRead_d;
      taErr_q    <= taErr_d;
      mdc_q      <= mdc_d;
      mdo_q      <= mdo_d;
      mdt_q      <= mdt_d;
      ready_q    <= ready_d;
      rspValid_q <= rspValid_d;
      rspErr_q   <= rspErr_d;
      rspData_q  <= rspData_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rspValid_q;
  assign rsp_err   = rspErr_q;
  assign rsp_data  = rspData_q;
  assign mdc       = mdc_q;
  assign mdo       = mdo_q;
  assign mdt       = mdt_q;

endmodule

// File: tb/tb_qnigma_mdio_master.sv
// tb_qnigma_mdio_master: directed bench for the MDIO master.
// Instance A uses a 32-bit preamble, instance B has the preamble suppressed;
// both run with MDC_DIV=4 and share the request fields, mdi and reset.
module tb_qnigma_mdio_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValidA, reqValidB;
  logic        reqC45;
  logic [1:0]  reqOp;
  logic [4:0]  reqPhyad, reqRegad;
  logic [15:0] reqData;
  logic        mdi;

  logic        readyA, rspValidA, rspErrA, mdcA, mdoA, mdtA;
  logic [15:0] rspDataA;
  logic        readyB, rspValidB, rspErrB, mdcB, mdoB, mdtB;
  logic [15:0] rspDataB;

  int checks   = 0;
  int failures = 0;

  logic [63:0] mdoBits, mdtBits;
  int          rspCycle, readyCycle, rspCount, mdcErrs;
  logic [15:0] gotData;
  logic        gotErr;
  int          strayRsp;

  qnigma_mdio_master #(.MDC_DIV(4), .PREAMBLE_BITS(32), .CLAUSE45_EN(1'b1)) dutA (
    .clk(clk), .rst(rst),
    .req_valid(reqValidA), .req_ready(readyA), .req_c45(reqC45), .req_op(reqOp),
    .req_phyad(reqPhyad), .req_regad(reqRegad), .req_data(reqData),
    .rsp_valid(rspValidA), .rsp_data(rspDataA), .rsp_err(rspErrA),
    .mdc(mdcA), .mdo(mdoA), .mdt(mdtA), .mdi(mdi)
  );

  qnigma_mdio_master #(.MDC_DIV(4), .PREAMBLE_BITS(0), .CLAUSE45_EN(1'b1)) dutB (
    .clk(clk), .rst(rst),
    .req_valid(reqValidB), .req_ready(readyB), .req_c45(reqC45), .req_op(reqOp),
    .req_phyad(reqPhyad), .req_regad(reqRegad), .req_data(reqData),
    .rsp_valid(rspValidB), .rsp_data(rspDataB), .rsp_err(rspErrB),
    .mdc(mdcB), .mdo(mdoB), .mdt(mdtB), .mdi(mdi)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request for a single cycle, then scramble the fields
  task automatic applyStimulus(input logic sel, input logic c45, input logic [1:0] op,
                               input logic [4:0] phy, input logic [4:0] regad,
                               input logic [15:0] data);
    reqC45   = c45;
    reqOp    = op;
    reqPhyad = phy;
    reqRegad = regad;
    reqData  = data;
    if (sel) reqValidB = 1'b1; else reqValidA = 1'b1;
    tick();
    reqValidA = 1'b0;
    reqValidB = 1'b0;
    reqC45    = ~c45;
    reqOp     = ~op;
    reqPhyad  = ~phy;
    reqRegad  = ~regad;
    reqData   = ~data;
  endtask

  // Follow a frame from cycle t+1, capturing bit streams and acting as the PHY
  task automatic runFrame(input logic sel, input int nBits, input logic taBit,
                          input logic [15:0] rdWord);
    int cyc;
    int b;
    logic oMdo, oMdt, oMdc, oRdy, oVal;
    mdoBits    = '0;
    mdtBits    = '0;
    rspCycle   = -1;
    readyCycle = -1;
    rspCount   = 0;
    mdcErrs    = 0;
    gotData    = 16'h0;
    gotErr     = 1'b0;
    for (cyc = 1; cyc < 600; cyc++) begin
      oMdo = sel ? mdoB : mdoA;
      oMdt = sel ? mdtB : mdtA;
      oMdc = sel ? mdcB : mdcA;
      oRdy = sel ? readyB : readyA;
      oVal = sel ? rspValidB : rspValidA;
      if (((cyc - 1) % 4) == 0) begin
        b = (cyc - 1) / 4;
        if (b < nBits) begin
          mdoBits = {mdoBits[62:0], oMdo};
          mdtBits = {mdtBits[62:0], oMdt};
          if (b == nBits - 17)      mdi = taBit;
          else if (b >= nBits - 16) mdi = rdWord[nBits - 1 - b];
          else                      mdi = 1'b1;
        end else begin
          mdi = 1'b1;
        end
      end
      if (oMdc !== (((cyc - 1) % 4) >= 2 && readyCycle < 0)) mdcErrs++;
      if (oVal) begin
        rspCount++;
        if (rspCycle < 0) begin
          rspCycle = cyc;
          gotData  = sel ? rspDataB : rspDataA;
          gotErr   = sel ? rspErrB : rspErrA;
        end
      end
      if (oRdy) begin
        readyCycle = cyc;
        break;
      end
      tick();
    end
    mdi = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    reqValidA = 1'b0;
    reqValidB = 1'b0;
    reqC45 = 1'b0;
    reqOp = 2'b00;
    reqPhyad = 5'd0;
    reqRegad = 5'd0;
    reqData = 16'h0;
    mdi = 1'b1;
    tick();
    tick();
    checkOutput("reset_ready", {63'd0, readyA}, 64'd1);
    checkOutput("reset_outs", {58'd0, rspValidA, rspErrA, mdcA, mdoA, mdtA, 1'b0}, 64'd0);
    checkOutput("reset_data", {48'd0, rspDataA}, 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] C22 write phy=5 reg=0x1F data=0xA5C3");
    applyStimulus(1'b0, 1'b0, 2'b01, 5'd5, 5'h1F, 16'hA5C3);
    runFrame(1'b0, 64, 1'b1, 16'hFFFF);
    checkOutput("wr_mdo", mdoBits,
                {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00101, 5'b11111, 2'b10, 16'hA5C3});
    checkOutput("wr_mdt", mdtBits, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("wr_rsp_cycle", 64'(rspCycle), 64'd257);
    checkOutput("wr_ready_cycle", 64'(readyCycle), 64'd261);
    checkOutput("wr_rsp_count", 64'(rspCount), 64'd1);
    checkOutput("wr_rsp_err", {63'd0, gotErr}, 64'd0);
    checkOutput("wr_rsp_data", {48'd0, gotData}, 64'd0);
    checkOutput("wr_mdc", 64'(mdcErrs), 64'd0);

    $display("[TB] C22 read phy=1 reg=2 with PHY returning 0x0141");
    applyStimulus(1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 16'h1234);
    runFrame(1'b0, 64, 1'b0, 16'h0141);
    checkOutput("rd_hdr", {18'd0, mdoBits[63:18]},
                {18'd0, 32'hFFFF_FFFF, 2'b01, 2'b10, 5'd1, 5'd2});
    checkOutput("rd_mdt", mdtBits, {{46{1'b1}}, {18{1'b0}}});
    checkOutput("rd_data", {48'd0, gotData}, 64'h0141);
    checkOutput("rd_err", {63'd0, gotErr}, 64'd0);
    checkOutput("rd_rsp_cycle", 64'(rspCycle), 64'd257);

    $display("[TB] C22 read with no PHY present");
    applyStimulus(1'b0, 1'b0, 2'b10, 5'd1, 5'd2, 16'h0000);
    runFrame(1'b0, 64, 1'b1, 16'hFFFF);
    checkOutput("nophy_err", {63'd0, gotErr}, 64'd1);
    checkOutput("nophy_data", {48'd0, gotData}, 64'hFFFF);

    $display("[TB] C45 address then C45 read");
    applyStimulus(1'b0, 1'b1, 2'b00, 5'd3, 5'd1, 16'h0010);
    runFrame(1'b0, 64, 1'b1, 16'hFFFF);
    checkOutput("c45a_mdo", mdoBits,
                {32'hFFFF_FFFF, 2'b00, 2'b00, 5'd3, 5'd1, 2'b10, 16'h0010});
    checkOutput("c45a_err", {63'd0, gotErr}, 64'd0);
    checkOutput("c45a_data", {48'd0, gotData}, 64'd0);
    applyStimulus(1'b0, 1'b1, 2'b11, 5'd3, 5'd1, 16'h0000);
    runFrame(1'b0, 64, 1'b0, 16'hBEEF);
    checkOutput("c45r_hdr", {18'd0, mdoBits[63:18]},
                {18'd0, 32'hFFFF_FFFF, 2'b00, 2'b11, 5'd3, 5'd1});
    checkOutput("c45r_data", {48'd0, gotData}, 64'hBEEF);
    checkOutput("c45r_err", {63'd0, gotErr}, 64'd0);

    $display("[TB] No-preamble instance: illegal C22 op 11 then a write");
    applyStimulus(1'b1, 1'b0, 2'b11, 5'd5, 5'd1, 16'h0000);
    checkOutput("ill_pulse", {61'd0, rspValidB, rspErrB, readyB}, {61'd0, 3'b110});
    checkOutput("ill_bus", {61'd0, mdcB, mdoB, mdtB}, 64'd0);
    tick();
    checkOutput("ill_after", {61'd0, rspValidB, mdcB, readyB}, {61'd0, 3'b001});
    applyStimulus(1'b1, 1'b0, 2'b01, 5'd5, 5'h1F, 16'hA5C3);
    runFrame(1'b1, 32, 1'b1, 16'hFFFF);
    checkOutput("np_mdo", {32'd0, mdoBits[31:0]},
                {32'd0, 2'b01, 2'b01, 5'b00101, 5'b11111, 2'b10, 16'hA5C3});
    checkOutput("np_mdt", {32'd0, mdtBits[31:0]}, 64'hFFFF_FFFF);
    checkOutput("np_rsp_cycle", 64'(rspCycle), 64'd129);
    checkOutput("np_ready_cycle", 64'(readyCycle), 64'd133);

    $display("[TB] Reset during REGAD");
    applyStimulus(1'b0, 1'b0, 2'b01, 5'd5, 5'h1F, 16'hA5C3);
    for (int i = 0; i < 168; i++) tick();
    checkOutput("abort_regad_mdo", {62'd0, mdoA, readyA}, {62'd0, 2'b10});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_outs", {60'd0, mdcA, mdoA, mdtA, readyA}, {60'd0, 4'b0001});
    strayRsp = 0;
    for (int i = 0; i < 300; i++) begin
      if (rspValidA) strayRsp++;
      tick();
    end
    checkOutput("abort_no_rsp", 64'(strayRsp), 64'd0);
    applyStimulus(1'b0, 1'b0, 2'b01, 5'd7, 5'd4, 16'h3C5A);
    runFrame(1'b0, 64, 1'b1, 16'hFFFF);
    checkOutput("post_mdo", mdoBits,
                {32'hFFFF_FFFF, 2'b01, 2'b01, 5'd7, 5'd4, 2'b10, 16'h3C5A});
    checkOutput("post_rsp_cycle", 64'(rspCycle), 64'd257);
    checkOutput("post_ready_cycle", 64'(readyCycle), 64'd261);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
